// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and
// the default operand width.
package sub_pkg;

   localparam int unsigned SUB_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing a - b - borrow_in over WIDTH
// cycles with a start/done handshake. Results hold until the next accept.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   , output logic           overflow
`endif
);

   localparam int unsigned    CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_bq;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             r_amsb;
   logic             r_bmsb;
   logic             r_ovf;
`endif

   logic             w_d;
   logic             w_bnext;
   logic [WIDTH-1:0] w_a_next;

   full_subtractor u_cell (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_bq),
      .d    (w_d),
      .bout (w_bnext)
   );

   // The minuend register doubles as the result accumulator: each consumed
   // LSB frees the MSB slot, which receives the new difference bit, so after
   // WIDTH shifts it holds the complete difference.
   assign w_a_next = {w_d, r_a[WIDTH-1:1]};

   // Handshake FSM, serial datapath and held result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_bq    <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         r_amsb  <= 1'b0;
         r_bmsb  <= 1'b0;
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_bq    <= borrow_in;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  r_amsb  <= a[WIDTH-1];
                  r_bmsb  <= b[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               r_a   <= w_a_next;
               r_b   <= {1'b0, r_b[WIDTH-1:1]};
               r_bq  <= w_bnext;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_diff  <= w_a_next;
                  r_bout  <= w_bnext;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  r_ovf   <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
`endif
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign diff       = r_diff;
   assign borrow_out = r_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign overflow   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). A cycle-level
// arithmetic model predicts every output each cycle; directed vectors pin
// the model with hand-computed literals.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         borrow_in = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         overflow;
`endif

   int unsigned  n_cmp = 0;
   int unsigned  n_bad = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .overflow (overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: cycles remaining in the busy window, results computed with plain arithmetic
   int           m_left = 0;
   logic [W-1:0] m_pd = '0;
   logic         m_pbo = 1'b0;
   logic         m_pov = 1'b0;
   logic [W-1:0] m_diff = '0;
   logic         m_bo = 1'b0;
   logic         m_ov = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      int sa, sb, r;
      if (!rst_n) begin
         m_left = 0;
         m_diff = '0;
         m_bo   = 1'b0;
         m_ov   = 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            m_left = W + 1;
            m_pd   = a - b - W'(borrow_in);
            m_pbo  = (9'(a) < (9'(b) + 9'(borrow_in)));
            sa     = (a >= 8'd128) ? int'(a) - 256 : int'(a);
            sb     = (b >= 8'd128) ? int'(b) - 256 : int'(b);
            r      = sa - sb - int'(borrow_in);
            m_pov  = (r < -128) || (r > 127);
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 1) begin
            m_diff = m_pd;
            m_bo   = m_pbo;
            m_ov   = m_pov;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy",       32'(busy),       32'(m_left != 0));
         check("done",       32'(done),       32'(m_left == 1));
         check("diff",       32'(diff),       32'(m_diff));
         check("borrow_out", 32'(borrow_out), 32'(m_bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         check("overflow",   32'(overflow),   32'(m_ov));
`endif
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy"},   32'(busy),       32'd0);
      check({tag, "_done"},   32'(done),       32'd0);
      check({tag, "_diff"},   32'(diff),       32'd0);
      check({tag, "_borrow"}, 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check({tag, "_ovf"},    32'(overflow),   32'd0);
`endif
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input logic [W-1:0] ed, input logic ebo, input logic eov,
                         input string tag);
      int lat;
      @(negedge clk);
      a = ta; b = tb; borrow_in = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
      check({tag, "_diff"},    32'(diff), 32'(ed));
      check({tag, "_borrow"},  32'(borrow_out), 32'(ebo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check({tag, "_ovf"},     32'(overflow), 32'(eov));
`else
      if (eov) begin end
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (timeout)");
      $fatal(1);
   end

   initial begin
      int lat;
      int nd;
      int t_first;
      int t_last;
      #12;
      check_zero("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;

      run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "5A_3C");
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "00_01");
      run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "10_0F_b1");
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "80_01");
      run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "7F_FF");
      run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "00_00_b1");
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "FF_FF_b1");

      // start pulses during SHIFT and DONE must be ignored
      @(negedge clk);
      a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; borrow_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("ign_latency", 32'(lat), 32'd8);
      a = 8'h01; b = 8'h02; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy_idle", 32'(busy), 32'd0);
      check("ign_diff", 32'(diff), 32'h22);
      @(negedge clk);
      check("ign_no_queue", 32'(busy), 32'd0);

      // start held high: back-to-back operations every WIDTH+2 cycles
      nd = 0; t_first = -1; t_last = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (t_first < 0) t_first = i;
            t_last = i;
         end
         a = 8'(i * 37 + 5); b = 8'(i * 91 + 3); borrow_in = i[0]; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      for (int i = 30; i < 45; i++) begin
         if (done) begin
            nd++;
            if (t_first < 0) t_first = i;
            t_last = i;
         end
         @(negedge clk);
      end
      check("b2b_count", 32'(nd), 32'd3);
      check("b2b_spacing", 32'(t_last - t_first), 32'd20);

      // asynchronous reset mid-SHIFT discards the operation
      run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      a = 8'h9C; b = 8'h27; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk);
      #1 check_zero("midrst_hold");
      #1 rst_n = 1'b1;
      run_op(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1, "post_rst");

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first two's-complement subtractor that computes A − B − borrow_in over WIDTH clock cycles using a single registered borrow. It sits beside the combinational adder datapath as a low-area arithmetic unit for multi-cycle paths, and has a start/done handshake so a controller can sequence it. The result is held stable until the next accepted start.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  input  1  initial borrow; captured on the accepting edge.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  A − B − borrow_in, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when the unsigned A < B + borrow_in.
- overflow  output  1  signed overflow; present only with the macro defined (see Configuration).

## Operation
- State machine states: IDLE, SHIFT, DONE.
- IDLE, start=1: capture a→shift_a, b→shift_b, borrow_in→borrow_q; clear bit counter; go to SHIFT.
- IDLE, start=0: remain in IDLE; outputs hold their last values.
- SHIFT: each cycle apply d = a0 ^ b0 ^ bq and bnext = (~a0 & b0) | (~(a0 ^ b0) & bq) to the LSBs.
- SHIFT: shift d into the result MSB and shift right; shift the operands right; borrow_q ← bnext; counter += 1.
- SHIFT, after the WIDTH-th shift: go to DONE.
- DONE: done=1; diff and borrow_out are valid. Next edge goes to IDLE unconditionally.
- start is ignored in SHIFT and DONE. It has no effect, and no request is queued.
- The counter is $clog2(WIDTH+1) bits wide. It never wraps, because it is cleared on every accept.
- diff, borrow_out and overflow hold from DONE until the next accepted start. Each is updated only on the DONE-entry edge, never with a partial result.
- Reset (asynchronous, any time, including mid-SHIFT): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0, internal shift registers and counter cleared. The in-flight operation is discarded.

## Timing
- Edge E0: start is accepted in IDLE.
- busy = 1 from E0 through the DONE cycle.
- SHIFT occupies edges E1…E_WIDTH.
- done is high for exactly the one cycle following edge E_WIDTH. Latency from the accepting edge to done is WIDTH+1 cycles.
- Earliest next accept: the edge that leaves DONE lands in IDLE. The following edge can accept, so throughput is one operation per WIDTH+2 cycles.
- start=1 held continuously produces back-to-back operations at that rate.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: the overflow port exists. It is set on the DONE-entry edge to (a_msb ≠ b_msb) & (diff_msb ≠ a_msb), using the captured operand MSBs, and holds like diff.
- Not defined: the overflow port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package sub_pkg: state enum (IDLE, SHIFT, DONE) and a localparam for the default width.
- Sub-module full_subtractor (inputs a, b, bin; outputs d, bout): purely combinational, instantiated once for the bit-serial cell. The implementation uses continuous assignments, and every output is declared as an output.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, borrow_in=0 -> done at cycle 9 after accept, diff=0x1E, borrow_out=0, overflow=0.
- a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1.
- a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0.
- Macro defined, a=0x80, b=0x01 -> diff=0x7F, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, overflow=1, borrow_out=1.
- Pulse start with new operands during SHIFT and during DONE -> ignored; the result matches the first operands; busy never drops early.
- Assert rst_n=0 at SHIFT cycle 4 -> all outputs 0 immediately, state IDLE. A fresh start after release gives a correct result 9 cycles later.
